button_mode_select: RTL
=======================

# button_mode_select

Upstream control stage for the LED blinker. Takes a raw board pushbutton, synchronises and debounces it, and advances a wrap-around mode index on each short press. The mode index drives the blinker's rate-select mux (0 = 10 Hz, 1 = 5 Hz, 2 = 2 Hz, 3 = 1 Hz). An optional long-press feature returns the mode to 0.

## Interface
- g_DEBOUNCE_LIMIT, 250000: number of consecutive cycles the synchronised input must differ from the clean state before the clean state flips (≥2).
- g_LONG_PRESS_LIMIT, 25000000: number of cycles the clean state must be held pressed to count as a long press (> g_DEBOUNCE_LIMIT).
- g_NUM_MODES, 4: number of modes (2..16); mode width is clog2(g_NUM_MODES).
- i_Clk, input, 1: system clock. The block has one clock only.
- i_Rst_L, input, 1: reset, synchronous and active-low.
- i_Switch, input, 1: raw, asynchronous, bouncy button; 1 = pressed.
- o_Switch_Clean, output, 1: debounced button level.
- o_Mode, output, clog2(g_NUM_MODES): current mode index.
- o_Mode_Change, output, 1: one-cycle pulse, asserted on the cycle o_Mode first shows a new value.
- o_Long_Press, output, 1: one-cycle pulse when a long press is recognised. Present only with LONG_PRESS_EN.

## Operation
- **Reset** (i_Rst_L = 0 at a rising edge): all of the following are cleared to 0 on that edge:
  - synchroniser flops, debounce counter, hold counter, long-press latch
  - o_Switch_Clean, o_Mode, o_Mode_Change, o_Long_Press
- **Reset mid-operation** aborts any debounce or hold count in progress. There is no partial mode advance.
- **Synchroniser:** two flops on i_Switch, producing r_Sync.
- **Debounce:**
  - Counter increments while r_Sync != o_Switch_Clean.
  - Counter clears to 0 on any cycle where they are equal. A glitch therefore restarts the count.
  - When the counter reaches g_DEBOUNCE_LIMIT-1 and the inputs still differ, o_Switch_Clean toggles and the counter clears.
- **Mode advance (without LONG_PRESS_EN):** on the clean rising edge (press):
  - o_Mode <= (o_Mode == g_NUM_MODES-1) ? 0 : o_Mode+1
  - o_Mode_Change pulses.
- **Mode advance (with LONG_PRESS_EN):** the advance happens on the clean falling edge (release), and only if the long-press latch is 0. The latch clears on release.
- **Long press (LONG_PRESS_EN):**
  - Hold counter counts cycles while o_Switch_Clean = 1, saturating at g_LONG_PRESS_LIMIT.
  - Reaching g_LONG_PRESS_LIMIT-1 sets the latch, forces o_Mode <= 0, and pulses o_Long_Press and o_Mode_Change together.
  - o_Mode_Change pulses even if the mode was already 0.
  - Hold counter clears when o_Switch_Clean = 0.
- **Wrap-around:** the mode after g_NUM_MODES-1 is 0. The mode never reaches g_NUM_MODES or above.
- **Simultaneous events:** a release in the same cycle the long-press threshold would be hit does not fire the long press. The release wins and is treated as a short press.

## Timing
- A clean change on i_Switch is first sampled at edge k. o_Switch_Clean updates at edge k+1+g_DEBOUNCE_LIMIT, provided the input stayed stable throughout.
- o_Mode and o_Mode_Change update one edge after the qualifying o_Switch_Clean edge.
- o_Mode_Change and o_Long_Press are high for exactly one cycle.
- Long press: o_Long_Press asserts exactly g_LONG_PRESS_LIMIT edges after o_Switch_Clean rose.
- Maximum rate is one mode change per complete press/release; back-to-back changes are never closer than 2·g_DEBOUNCE_LIMIT cycles.

## Configuration
- **Macro:** LONG_PRESS_EN.
- **Defined:** the hold counter, latch and o_Long_Press port are present, and the mode advances on release.
- **Undefined:** the hold counter and latch are not instantiated, the o_Long_Press port is absent, the mode advances on press, and g_LONG_PRESS_LIMIT is ignored.

## Structure
- **Shared package blink_pkg:**
  - mode encodings MODE_10HZ = 0, MODE_5HZ = 1, MODE_2HZ = 2, MODE_1HZ = 3
  - the mode-width constant/function
  - default debounce and long-press limits for the 25 MHz board clock
- **Sub-module debounce_filter:** the synchroniser plus debounce counter, with i_Clk, i_Rst_L, i_Raw and o_Clean. It is reusable for the other board switches.
- **Top level:** edge detect, the mode counter and the long-press logic.

## Test plan
All scenarios use g_DEBOUNCE_LIMIT = 4, g_LONG_PRESS_LIMIT = 20, g_NUM_MODES = 4.
- Hold i_Rst_L = 0 for 3 cycles with i_Switch = 1 → all outputs 0; after release, o_Switch_Clean rises 5 edges after the first sample.
- Bounce pattern 1,0,1,0,1 at one-cycle spacing, then stable 1 → no clean change until 4 stable cycles; exactly one o_Mode_Change.
- Four full short presses from mode 0 → o_Mode sequence 1, 2, 3, 0 (this is the no-macro case; with LONG_PRESS_EN the updates land on release instead); four o_Mode_Change pulses.
- LONG_PRESS_EN, mode 2, hold for 30 cycles after clean → o_Long_Press and o_Mode_Change pulse on clean+20; o_Mode = 0; release gives no further advance.
- LONG_PRESS_EN, release exactly at the threshold cycle → no o_Long_Press; o_Mode advances by 1.
- Assert i_Rst_L = 0 mid-debounce, 2 cycles into a press → o_Switch_Clean stays 0 and o_Mode stays 0; the press after reset requires the full 4 stable cycles again.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared constants for the LED blinker: mode encodings, mode-width helper and
// default switch timing limits for the 25 MHz board clock.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_10HZ = 2'd0,
        MODE_5HZ  = 2'd1,
        MODE_2HZ  = 2'd2,
        MODE_1HZ  = 2'd3
    } mode_e;

    // 10 ms debounce and 1 s long press at 25 MHz.
    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT   = 250000;
    localparam int unsigned DEFAULT_LONG_PRESS_LIMIT = 25000000;

    function automatic int unsigned mode_width(input int unsigned num_modes);
        return (num_modes <= 2) ? 1 : $clog2(num_modes);
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus consecutive-cycle debounce counter for a raw board
// switch; o_Clean flips only after g_DEBOUNCE_LIMIT cycles of a stable new level.
module debounce_filter
    import blink_pkg::*;
#(
    parameter int unsigned g_DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Raw,
    output logic o_Clean
);

    localparam int unsigned CNT_W = $clog2(g_DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(g_DEBOUNCE_LIMIT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = i_Raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        cnt_d   = '0;
        // Any cycle where the synchronised level agrees restarts the count.
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = ~clean_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_Clean = clean_q;

endmodule

// File: rtl/button_mode_select.sv
// Pushbutton to wrap-around blink-mode index. Define LONG_PRESS_EN to advance on
// release instead of press and to let a long hold force the mode back to 0.
module button_mode_select
    import blink_pkg::*;
#(
    parameter int unsigned g_DEBOUNCE_LIMIT   = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned g_LONG_PRESS_LIMIT = DEFAULT_LONG_PRESS_LIMIT,
    parameter int unsigned g_NUM_MODES        = 4,
    localparam int unsigned MODE_W            = mode_width(g_NUM_MODES)
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Switch,
    output logic              o_Switch_Clean,
    output logic [MODE_W-1:0] o_Mode,
    output logic              o_Mode_Change
`ifdef LONG_PRESS_EN
    ,
    output logic              o_Long_Press
`endif
);

    if (g_DEBOUNCE_LIMIT < 2 || g_NUM_MODES < 2 || g_NUM_MODES > 16) begin : g_bad_cfg
        $error("button_mode_select: illegal debounce limit or mode count");
    end
    if (g_LONG_PRESS_LIMIT <= g_DEBOUNCE_LIMIT) begin : g_bad_long
        $error("button_mode_select: long-press limit must exceed debounce limit");
    end

    localparam logic [MODE_W-1:0] MODE_FIRST = MODE_W'(MODE_10HZ);
    localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(g_NUM_MODES - 1);

    logic              clean;
    logic              clean_prev_q, clean_prev_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              mode_change_q, mode_change_d;
    logic [MODE_W-1:0] mode_inc;

    debounce_filter #(
        .g_DEBOUNCE_LIMIT(g_DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Raw  (i_Switch),
        .o_Clean(clean)
    );

    assign mode_inc = (mode_q == MODE_LAST) ? MODE_FIRST : mode_q + 1'b1;

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(g_LONG_PRESS_LIMIT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(g_LONG_PRESS_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(g_LONG_PRESS_LIMIT - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              latch_q, latch_d;
    logic              long_press_q, long_press_d;
    logic              fall;

    assign fall = ~clean & clean_prev_q;

    always_comb begin
        clean_prev_d  = clean;
        mode_d        = mode_q;
        mode_change_d = 1'b0;
        long_press_d  = 1'b0;
        latch_d       = latch_q;
        hold_d        = '0;
        if (clean) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
        // A release already seen as clean=0 can never coincide with the fire cycle.
        if (clean && hold_q == HOLD_FIRE) begin
            mode_d        = MODE_FIRST;
            mode_change_d = 1'b1;
            long_press_d  = 1'b1;
            latch_d       = 1'b1;
        end else if (fall) begin
            latch_d = 1'b0;
            if (!latch_q) begin
                mode_d        = mode_inc;
                mode_change_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            hold_q       <= '0;
            latch_q      <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            latch_q      <= latch_d;
            long_press_q <= long_press_d;
        end
    end

    assign o_Long_Press = long_press_q;
`else
    logic rise;

    assign rise = clean & ~clean_prev_q;

    always_comb begin
        clean_prev_d  = clean;
        mode_d        = mode_q;
        mode_change_d = 1'b0;
        if (rise) begin
            mode_d        = mode_inc;
            mode_change_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            clean_prev_q  <= 1'b0;
            mode_q        <= MODE_FIRST;
            mode_change_q <= 1'b0;
        end else begin
            clean_prev_q  <= clean_prev_d;
            mode_q        <= mode_d;
            mode_change_q <= mode_change_d;
        end
    end

    assign o_Switch_Clean = clean;
    assign o_Mode         = mode_q;
    assign o_Mode_Change  = mode_change_q;

endmodule
